// File: rtl/core2ahb3lite_pipe.sv
// Pipelined core req/gnt/rvalid to AHB3-Lite master bridge: address phase of N+1 overlaps data phase of N.
// Optional define CORE2AHB_RESP_REG_EN registers rvalid_o/err_o/rdata_o (one extra cycle of response latency).
module core2ahb3lite_pipe #(
  parameter int          AHB_ADDR_WIDTH = 32,
  parameter int          AHB_DATA_WIDTH = 32,
  parameter bit          PIPELINED      = 1'b1,
  parameter logic [3:0]  HPROT_VALUE    = 4'b0011,
  localparam int         BE_WIDTH       = AHB_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic                      err_o,
  input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [BE_WIDTH-1:0]       be_i,
  input  logic [AHB_DATA_WIDTH-1:0] wdata_i,
  output logic [AHB_DATA_WIDTH-1:0] rdata_o,
  output logic [AHB_ADDR_WIDTH-1:0] HADDR_o,
  output logic [AHB_DATA_WIDTH-1:0] HWDATA_o,
  input  logic [AHB_DATA_WIDTH-1:0] HRDATA_i,
  output logic                      HWRITE_o,
  output logic [2:0]                HSIZE_o,
  output logic [2:0]                HBURST_o,
  output logic [3:0]                HPROT_o,
  output logic [1:0]                HTRANS_o,
  output logic                      HMASTLOCK_o,
  input  logic                      HREADY_i,
  input  logic                      HRESP_i
);

  localparam int LOG2_BE = $clog2(BE_WIDTH);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  logic                      r_dp_valid;
  logic                      r_dp_we;
  logic [AHB_DATA_WIDTH-1:0] r_dp_wdata;

  logic                      w_block;
  logic                      w_gnt;
  logic                      w_rvalid;
  logic                      w_err;
  logic [AHB_DATA_WIDTH-1:0] w_rdata;
  logic [2:0]                w_size;
  logic [LOG2_BE-1:0]        w_low;
  logic                      w_unused_addr;

  assign w_unused_addr = ^addr_i[LOG2_BE-1:0];

  // An ERROR response always stalls new transfers; without pipelining a pending data phase does too.
  assign w_block = (r_dp_valid & HRESP_i) |
                   ((PIPELINED == 1'b0) & r_dp_valid & ~HREADY_i);
  assign w_gnt   = req_i & HREADY_i & ~w_block;

  // Size decode: find an aligned contiguous run of 2^k bytes; anything else falls back to full width.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    w_size = 3'(LOG2_BE);
    w_low  = '0;
    for (int k = 0; k <= LOG2_BE; k++) begin
      for (int o = 0; o < BE_WIDTH; o += (1 << k)) begin
        if (be_i == BE_WIDTH'(((1 << (1 << k)) - 1) << o)) begin
          w_size = 3'(k);
          w_low  = LOG2_BE'(o);
        end
      end
    end
  end

  assign gnt_o       = w_gnt;
  assign HTRANS_o    = (req_i & ~w_block) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE_o    = we_i;
  assign HADDR_o     = req_i ? {addr_i[AHB_ADDR_WIDTH-1:LOG2_BE], w_low} : '0;
  assign HSIZE_o     = req_i ? w_size : 3'b000;
  assign HBURST_o    = 3'b000;
  assign HPROT_o     = HPROT_VALUE;
  assign HMASTLOCK_o = 1'b0;
  assign HWDATA_o    = (r_dp_valid & r_dp_we) ? r_dp_wdata : '0;

  // A grant loads the data phase in the same edge that retires the previous one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_dp_valid <= 1'b0;
      r_dp_we    <= 1'b0;
      r_dp_wdata <= '0;
    end else if (w_gnt) begin
      r_dp_valid <= 1'b1;
      r_dp_we    <= we_i;
      r_dp_wdata <= wdata_i;
    end else if (HREADY_i) begin
      r_dp_valid <= 1'b0;
    end
  end

  assign w_rvalid = r_dp_valid & HREADY_i;
  assign w_err    = w_rvalid & HRESP_i;
  assign w_rdata  = (w_rvalid & ~r_dp_we & ~HRESP_i) ? HRDATA_i : '0;

`ifdef CORE2AHB_RESP_REG_EN
  logic                      r_rvalid;
  logic                      r_err;
  logic [AHB_DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rvalid;
      r_err    <= w_err;
      r_rdata  <= w_rdata;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;
`else
  assign rvalid_o = w_rvalid;
  assign err_o    = w_err;
  assign rdata_o  = w_rdata;
`endif

endmodule

// File: tb/tb_core2ahb3lite_pipe.sv
// Directed self-checking bench for core2ahb3lite_pipe (default build: 32-bit, pipelined, combinational response).
module tb_core2ahb3lite_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic          err_o;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [BW-1:0] be_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] HADDR_o;
  logic [DW-1:0] HWDATA_o;
  logic [DW-1:0] HRDATA_i;
  logic          HWRITE_o;
  logic [2:0]    HSIZE_o;
  logic [2:0]    HBURST_o;
  logic [3:0]    HPROT_o;
  logic [1:0]    HTRANS_o;
  logic          HMASTLOCK_o;
  logic          HREADY_i;
  logic          HRESP_i;

  int n_checks = 0;
  int n_errors = 0;

  core2ahb3lite_pipe dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .err_o       (err_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .HADDR_o     (HADDR_o),
    .HWDATA_o    (HWDATA_o),
    .HRDATA_i    (HRDATA_i),
    .HWRITE_o    (HWRITE_o),
    .HSIZE_o     (HSIZE_o),
    .HBURST_o    (HBURST_o),
    .HPROT_o     (HPROT_o),
    .HTRANS_o    (HTRANS_o),
    .HMASTLOCK_o (HMASTLOCK_o),
    .HREADY_i    (HREADY_i),
    .HRESP_i     (HRESP_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [AW-1:0] addr, input logic we,
                       input logic [BW-1:0] be, input logic [DW-1:0] wdata);
    req_i   = req;
    addr_i  = addr;
    we_i    = we;
    be_i    = be;
    wdata_i = wdata;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni   = 1'b0;
    HREADY_i = 1'b1;
    HRESP_i  = 1'b0;
    HRDATA_i = '0;
    drive(1'b0, '0, 1'b0, '0, '0);
    #2;
    check("rst_htrans", 64'(HTRANS_o), 64'h0);
    check("rst_gnt",    64'(gnt_o),    64'h0);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    check("rst_err",    64'(err_o),    64'h0);
    check("rst_haddr",  64'(HADDR_o),  64'h0);
    check("rst_hwdata", 64'(HWDATA_o), 64'h0);
    check("rst_hwrite", 64'(HWRITE_o), 64'h0);
    check("hburst",     64'(HBURST_o), 64'h0);
    check("hprot",      64'(HPROT_o),  64'h3);
    check("hmastlock",  64'(HMASTLOCK_o), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;

    // 1: idle after reset release
    for (int i = 0; i < 3; i++) begin
      mid();
      check("idle_htrans", 64'(HTRANS_o), 64'h0);
      check("idle_gnt",    64'(gnt_o),    64'h0);
      check("idle_rvalid", 64'(rvalid_o), 64'h0);
      tick();
    end

    // 2: four back-to-back word reads, responses one cycle behind grants
    drive(1'b1, 32'h100, 1'b0, 4'hF, '0);
    mid();
    check("b2b0_gnt",    64'(gnt_o),    64'h1);
    check("b2b0_htrans", 64'(HTRANS_o), 64'h2);
    check("b2b0_haddr",  64'(HADDR_o),  64'h100);
    check("b2b0_hsize",  64'(HSIZE_o),  64'h2);
    check("b2b0_rvalid", 64'(rvalid_o), 64'h0);
    tick();
    drive(1'b1, 32'h104, 1'b0, 4'hF, '0);
    HRDATA_i = 32'h100;
    mid();
    check("b2b1_gnt",    64'(gnt_o),    64'h1);
    check("b2b1_haddr",  64'(HADDR_o),  64'h104);
    check("b2b1_rvalid", 64'(rvalid_o), 64'h1);
    check("b2b1_rdata",  64'(rdata_o),  64'h100);
    tick();
    drive(1'b1, 32'h108, 1'b0, 4'hF, '0);
    HRDATA_i = 32'h104;
    mid();
    check("b2b2_gnt",    64'(gnt_o),    64'h1);
    check("b2b2_rvalid", 64'(rvalid_o), 64'h1);
    check("b2b2_rdata",  64'(rdata_o),  64'h104);
    tick();
    drive(1'b1, 32'h10C, 1'b0, 4'hF, '0);
    HRDATA_i = 32'h108;
    mid();
    check("b2b3_gnt",    64'(gnt_o),    64'h1);
    check("b2b3_haddr",  64'(HADDR_o),  64'h10C);
    check("b2b3_rvalid", 64'(rvalid_o), 64'h1);
    check("b2b3_rdata",  64'(rdata_o),  64'h108);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    HRDATA_i = 32'h10C;
    mid();
    check("b2b4_gnt",    64'(gnt_o),    64'h0);
    check("b2b4_htrans", 64'(HTRANS_o), 64'h0);
    check("b2b4_rvalid", 64'(rvalid_o), 64'h1);
    check("b2b4_rdata",  64'(rdata_o),  64'h10C);
    tick();
    mid();
    check("b2b5_rvalid", 64'(rvalid_o), 64'h0);
    tick();

    // 3: byte write, then size-decode corner cases chained behind it
    drive(1'b1, 32'h203, 1'b1, 4'b1000, 32'hAB000000);
    HRDATA_i = 32'hFFFF_FFFF;
    mid();
    check("wr_gnt",    64'(gnt_o),    64'h1);
    check("wr_haddr",  64'(HADDR_o),  64'h203);
    check("wr_hsize",  64'(HSIZE_o),  64'h0);
    check("wr_hwrite", 64'(HWRITE_o), 64'h1);
    check("wr_hwdata_early", 64'(HWDATA_o), 64'h0);
    tick();
    drive(1'b1, 32'h300, 1'b0, 4'b1100, '0);
    mid();
    check("wr_hwdata",  64'(HWDATA_o), 64'hAB000000);
    check("wr_rvalid",  64'(rvalid_o), 64'h1);
    check("wr_rdata",   64'(rdata_o),  64'h0);
    check("half_haddr", 64'(HADDR_o),  64'h302);
    check("half_hsize", 64'(HSIZE_o),  64'h1);
    check("half_hwrite", 64'(HWRITE_o), 64'h0);
    tick();
    drive(1'b1, 32'h405, 1'b0, 4'b0101, '0);
    HRDATA_i = 32'h5555_0000;
    mid();
    check("half_hwdata", 64'(HWDATA_o), 64'h0);
    check("half_rdata",  64'(rdata_o),  64'h5555_0000);
    check("noncont_haddr", 64'(HADDR_o), 64'h404);
    check("noncont_hsize", 64'(HSIZE_o), 64'h2);
    tick();
    drive(1'b1, 32'h207, 1'b0, 4'b0000, '0);
    mid();
    check("bezero_haddr", 64'(HADDR_o), 64'h204);
    check("bezero_hsize", 64'(HSIZE_o), 64'h2);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    mid();
    check("chain_tail_rvalid", 64'(rvalid_o), 64'h1);
    tick();
    mid();
    check("chain_idle_rvalid", 64'(rvalid_o), 64'h0);
    tick();

    // 4: read followed by two wait states with a second request pending
    drive(1'b1, 32'h500, 1'b0, 4'hF, '0);
    mid();
    check("ws_gnt0", 64'(gnt_o), 64'h1);
    tick();
    drive(1'b1, 32'h504, 1'b0, 4'hF, '0);
    HREADY_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("ws_gnt_held", 64'(gnt_o),    64'h0);
      check("ws_rvalid",   64'(rvalid_o), 64'h0);
      check("ws_htrans",   64'(HTRANS_o), 64'h2);
      check("ws_haddr",    64'(HADDR_o),  64'h504);
      tick();
    end
    HREADY_i = 1'b1;
    HRDATA_i = 32'h500;
    mid();
    check("ws_gnt1",    64'(gnt_o),    64'h1);
    check("ws_rvalid1", 64'(rvalid_o), 64'h1);
    check("ws_rdata1",  64'(rdata_o),  64'h500);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    HRDATA_i = 32'h504;
    mid();
    check("ws_rvalid2", 64'(rvalid_o), 64'h1);
    check("ws_rdata2",  64'(rdata_o),  64'h504);
    tick();
    mid();
    check("ws_rvalid3", 64'(rvalid_o), 64'h0);
    tick();

    // 5: two-cycle ERROR response with the next request pending
    drive(1'b1, 32'h600, 1'b0, 4'hF, '0);
    mid();
    check("er_gnt0", 64'(gnt_o), 64'h1);
    tick();
    drive(1'b1, 32'h604, 1'b0, 4'hF, '0);
    HREADY_i = 1'b0;
    HRESP_i  = 1'b1;
    HRDATA_i = 32'hDEAD_BEEF;
    mid();
    check("er1_gnt",    64'(gnt_o),    64'h0);
    check("er1_htrans", 64'(HTRANS_o), 64'h0);
    check("er1_rvalid", 64'(rvalid_o), 64'h0);
    tick();
    HREADY_i = 1'b1;
    mid();
    check("er2_htrans", 64'(HTRANS_o), 64'h0);
    check("er2_gnt",    64'(gnt_o),    64'h0);
    check("er2_rvalid", 64'(rvalid_o), 64'h1);
    check("er2_err",    64'(err_o),    64'h1);
    check("er2_rdata",  64'(rdata_o),  64'h0);
    tick();
    HRESP_i = 1'b0;
    mid();
    check("er3_htrans", 64'(HTRANS_o), 64'h2);
    check("er3_gnt",    64'(gnt_o),    64'h1);
    check("er3_haddr",  64'(HADDR_o),  64'h604);
    check("er3_rvalid", 64'(rvalid_o), 64'h0);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    HRDATA_i = 32'h604;
    mid();
    check("er4_rvalid", 64'(rvalid_o), 64'h1);
    check("er4_err",    64'(err_o),    64'h0);
    check("er4_rdata",  64'(rdata_o),  64'h604);
    tick();

    // 6: reset during a stalled write data phase drops the transfer
    drive(1'b1, 32'h700, 1'b1, 4'hF, 32'h1234_5678);
    mid();
    check("rs_gnt", 64'(gnt_o), 64'h1);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    HREADY_i = 1'b0;
    mid();
    check("rs_hwdata_pending", 64'(HWDATA_o), 64'h1234_5678);
    check("rs_rvalid_pending", 64'(rvalid_o), 64'h0);
    rst_ni = 1'b0;
    #1;
    check("rs_hwdata_cleared", 64'(HWDATA_o), 64'h0);
    tick();
    rst_ni   = 1'b1;
    HREADY_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("rs_no_rvalid", 64'(rvalid_o), 64'h0);
      check("rs_hwdata",    64'(HWDATA_o), 64'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core2ahb3lite_pipe.md
Name: core2ahb3lite_pipe

Overview:
Parametrised, pipelined successor to the core-side req/gnt/rvalid to AHB3-Lite master bridge used on the instruction and data ports of the RISC-V top.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N, giving one transfer per cycle at zero wait states.
- Generalises data width to 32/64 bits and derives HSIZE/HADDR from byte enables.
- Propagates AHB ERROR responses to the core as err_o.

Parameters:
AHB_ADDR_WIDTH, 32, address bus width.
AHB_DATA_WIDTH, 32, data bus width; legal values 32 or 64; BE_WIDTH = AHB_DATA_WIDTH/8.
PIPELINED, 1, 1 = address/data phase overlap; 0 = no new grant while a data phase is pending.
HPROT_VALUE, 4'b0011, constant driven on HPROT_o (instruction port instance uses 4'b0010).

Ports:
clk_i  in  1  clock (HCLK)
rst_ni  in  1  asynchronous active-low reset (HRESETn)
req_i  in  1  core request; addr/we/be/wdata stable until gnt_o
gnt_o  out  1  request accepted (AHB address phase completed this cycle)
rvalid_o  out  1  response valid
err_o  out  1  response is an AHB ERROR; qualified by rvalid_o
addr_i  in  AHB_ADDR_WIDTH  byte address
we_i  in  1  write
be_i  in  BE_WIDTH  byte enables
wdata_i  in  AHB_DATA_WIDTH  write data
rdata_o  out  AHB_DATA_WIDTH  read data
HADDR_o  out  AHB_ADDR_WIDTH  AHB address
HWDATA_o  out  AHB_DATA_WIDTH  AHB write data
HRDATA_i  in  AHB_DATA_WIDTH  AHB read data
HWRITE_o  out  1  AHB write
HSIZE_o  out  3  AHB size
HBURST_o  out  3  constant 3'b000 (SINGLE)
HPROT_o  out  4  constant HPROT_VALUE
HTRANS_o  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
HMASTLOCK_o  out  1  constant 0
HREADY_i  in  1  AHB ready
HRESP_i  in  1  AHB response; 1 = ERROR

Behaviour:
- Reset (rst_ni low, async):
  - data-phase register cleared (dp_valid = 0, dp_we = 0, dp_wdata = 0).
  - HTRANS_o = IDLE, gnt_o = 0, rvalid_o = 0, err_o = 0, HADDR_o = 0, HWDATA_o = 0, HWRITE_o = 0.
  - Any in-flight transfer is dropped; no response is issued for it.
- Address phase (combinational from the core request):
  - block = dp_valid & HRESP_i, or (PIPELINED = 0 and dp_valid & !HREADY_i).
  - HTRANS_o = NONSEQ when req_i & !block; otherwise IDLE.
  - gnt_o = req_i & HREADY_i & !block.
  - HWRITE_o = we_i; HADDR_o / HSIZE_o driven while req_i, else 0.
- Size decode:
  - be_i a contiguous run of 2^k bytes aligned to 2^k: HSIZE_o = k; HADDR_o = {addr_i[AW-1:log2(BE_WIDTH)], index of lowest set bit}.
  - Any other pattern, including all-zero: HSIZE_o = log2(BE_WIDTH) (full width); HADDR_o aligned down to that width.
- Data phase:
  - On gnt_o: dp_valid <= 1, dp_we <= we_i, dp_wdata <= wdata_i, in the same edge that retires the previous data phase.
  - If HREADY_i and no gnt: dp_valid <= 0.
  - HWDATA_o = dp_wdata while dp_valid & dp_we, else 0.
- Response (latency 0 from data-phase completion):
  - rvalid_o = dp_valid & HREADY_i.
  - err_o = rvalid_o & HRESP_i.
  - rdata_o = HRDATA_i on a read without error, else 0.
- ERROR handling (two-cycle):
  - Cycle 1 (HRESP=1, HREADY=0): no grant.
  - Cycle 2 (HRESP=1, HREADY=1): HTRANS_o forced IDLE, gnt_o = 0, rvalid_o = err_o = 1.
  - The pending request is presented again the following cycle.
- Simultaneous completion and new grant (PIPELINED = 1): rvalid_o for N and gnt_o for N+1 in the same cycle.
- Max outstanding = 2 (one address phase, one data phase). With PIPELINED = 0, max outstanding = 1.

Optional Feature:
CORE2AHB_RESP_REG_EN:
- Defined: rvalid_o, err_o and rdata_o are registered.
  - Response appears 1 cycle after data-phase completion.
  - Registers reset to 0.
  - Grants are unchanged and back-to-back throughput is kept.
- Undefined: combinational response as described above.

Test Plan:
1. Reset release, req_i = 0 -> HTRANS_o = IDLE, gnt_o = 0, rvalid_o = 0 on every cycle.
2. Four back-to-back word reads at 0x100..0x10C, HREADY = 1, HRDATA = addr -> gnt_o on 4 consecutive cycles; rvalid_o on the 4 following cycles with rdata_o = 0x100, 0x104, 0x108, 0x10C.
3. Write to 0x203 with be = 4'b1000, wdata = 0xAB000000 -> HADDR_o = 0x203, HSIZE_o = 0, HWRITE_o = 1; HWDATA_o = 0xAB000000 in the next cycle.
4. Read, then 2 wait states (HREADY = 0) with a second request pending -> gnt for the second request withheld until HREADY = 1; HADDR_o held stable; rvalid_o pulses exactly once per transfer.
5. ERROR response on a read with the next request pending -> cycle 2 shows HTRANS_o = IDLE and rvalid_o = err_o = 1, rdata_o = 0; next cycle NONSEQ for the pending request.
6. rst_ni asserted during a data phase with HREADY = 0 -> after release, no rvalid_o is issued for the dropped transfer.
